// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and alignment rule for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      MASK_BYTE = 2'b00,
      MASK_HALF = 2'b01,
      MASK_WORD = 2'b10,
      MASK_RSVD = 2'b11
   } mask_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_WRITE,
      ST_RESP
   } state_e;

   // The reserved encoding behaves as a word access.
   function automatic logic is_misaligned(input logic [1:0] mask_op, input logic [1:0] addr_lo);
      logic r;
      case (mask_op)
         MASK_BYTE: r = 1'b0;
         MASK_HALF: r = addr_lo[0];
         default:   r = (addr_lo != 2'b00);
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_lane_fmt.sv
// Lane steering: load extraction with optional sign extension, and sub-word store merge.
module lsu_lane_fmt
   import lsu_pkg::*;
(
   input  logic [1:0]  mask_op_i,
   input  logic        sign_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] raw_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = raw_i[{addr_lo_i, 3'b000} +: 8];
   assign w_half = raw_i[{addr_lo_i[1], 4'b0000} +: 16];

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      load_o   = raw_i;
      merged_o = raw_i;
      case (mask_op_i)
         MASK_BYTE: begin
            load_o = {{24{sign_i & w_byte[7]}}, w_byte};
            merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         MASK_HALF: begin
            load_o = {{16{sign_i & w_half[15]}}, w_half};
            merged_o[{addr_lo_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            load_o   = raw_i;
            merged_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one request at a time against a single-port synchronous data memory.
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  mask_op_i,
   input  logic        sign_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic        mem_en_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

   state_e      r_state, w_next;
   logic [2:0]  r_cnt;
   logic        r_we, r_sign, r_misalign;
   logic [1:0]  r_mask;
   logic [31:0] r_addr, r_wdata, r_buf, r_rdata;

   logic        w_accept, w_mis, w_last_wait;
   logic [31:0] w_raw, w_load, w_merged;

   assign w_accept    = (r_state == ST_IDLE) && req_valid_i;
   assign w_mis       = is_misaligned(mask_op_i, addr_i[1:0]);
   assign w_last_wait = (r_state == ST_WAIT) && (r_cnt == 3'd0);
   // Loads format the word as it arrives; stores merge into the buffered copy.
   assign w_raw       = (r_state == ST_WRITE) ? r_buf : mem_rdata_i;

   lsu_lane_fmt u_fmt (
      .mask_op_i (r_mask),
      .sign_i    (r_sign),
      .addr_lo_i (r_addr[1:0]),
      .raw_i     (w_raw),
      .wdata_i   (r_wdata),
      .load_o    (w_load),
      .merged_o  (w_merged)
   );

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_sign     <= 1'b0;
         r_mask     <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_buf      <= '0;
         r_rdata    <= '0;
         r_misalign <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_we       <= req_we_i;
            r_mask     <= mask_op_i;
            r_sign     <= sign_i;
            r_addr     <= addr_i;
            r_wdata    <= wdata_i;
            r_misalign <= w_mis;
         end
         if (r_state == ST_READ)
            r_cnt <= CNT_INIT;
         else if (r_state == ST_WAIT && r_cnt != 3'd0)
            r_cnt <= r_cnt - 3'd1;
         if (w_last_wait) begin
            r_buf <= mem_rdata_i;
            if (!r_we)
               r_rdata <= w_load;
         end
         if (r_state == ST_RESP)
            r_misalign <= 1'b0;
      end
   end

   // Memory strobes decode the state directly, so an asserted reset silences them at once.
   always_comb begin
      w_next      = r_state;
      req_ready_o = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready_o = rst_n_i;
            if (req_valid_i) begin
               if (w_mis)
                  w_next = ST_RESP;
               else if (req_we_i && mask_op_i[1])
                  w_next = ST_WRITE;
               else
                  w_next = ST_READ;
            end
         end
         ST_READ: begin
            mem_en_o   = 1'b1;
            mem_addr_o = {r_addr[31:2], 2'b00};
            w_next     = ST_WAIT;
         end
         ST_WAIT: begin
            mem_addr_o = {r_addr[31:2], 2'b00};
            if (r_cnt == 3'd0)
               w_next = r_we ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {r_addr[31:2], 2'b00};
            mem_wdata_o = w_merged;
            w_next      = ST_RESP;
         end
         ST_RESP: begin
            mem_addr_o = {r_addr[31:2], 2'b00};
            w_next     = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   assign resp_valid_o = (r_state == ST_RESP);
   assign misalign_o   = r_misalign;
   // Store and fault completions report zero without disturbing the last loaded value.
   assign rdata_o      = (resp_valid_o && (r_we || r_misalign)) ? 32'h0 : r_rdata;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: two instances (MEM_LAT=1 and 3), each with a behavioural memory.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we, req_sign;
   logic [1:0]  req_mask;
   logic [31:0] req_addr, req_wdata;
   bit          use3;

   logic        ready1, resp1, mis1, en1, we1;
   logic [31:0] rdata1, maddr1, mwdata1, mrdata1;
   logic        ready3, resp3, mis3, en3, we3;
   logic [31:0] rdata3, maddr3, mwdata3, mrdata3;

   logic        valid1, valid3;
   logic        ready, resp, mis, en, we;
   logic [31:0] rdata, maddr, mwdata;

   logic [31:0] mem1 [0:1023];
   logic [31:0] mem3 [0:1023];
   logic [31:0] pipe3 [0:2];

   int en_cnt = 0, we_cnt = 0, acc_cnt = 0;
   logic [31:0] last_waddr = '0, last_wdata = '0;
   int n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   assign valid1 = req_valid & ~use3;
   assign valid3 = req_valid & use3;
   assign ready  = use3 ? ready3  : ready1;
   assign resp   = use3 ? resp3   : resp1;
   assign mis    = use3 ? mis3    : mis1;
   assign en     = use3 ? en3     : en1;
   assign we     = use3 ? we3     : we1;
   assign rdata  = use3 ? rdata3  : rdata1;
   assign maddr  = use3 ? maddr3  : maddr1;
   assign mwdata = use3 ? mwdata3 : mwdata1;

   lsu_ctrl #(.MEM_LAT(1)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid1), .req_ready_o(ready1),
      .req_we_i(req_we), .mask_op_i(req_mask), .sign_i(req_sign), .addr_i(req_addr),
      .wdata_i(req_wdata), .resp_valid_o(resp1), .rdata_o(rdata1), .misalign_o(mis1),
      .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(maddr1), .mem_wdata_o(mwdata1),
      .mem_rdata_i(mrdata1)
   );

   lsu_ctrl #(.MEM_LAT(3)) u_dut3 (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(valid3), .req_ready_o(ready3),
      .req_we_i(req_we), .mask_op_i(req_mask), .sign_i(req_sign), .addr_i(req_addr),
      .wdata_i(req_wdata), .resp_valid_o(resp3), .rdata_o(rdata3), .misalign_o(mis3),
      .mem_en_o(en3), .mem_we_o(we3), .mem_addr_o(maddr3), .mem_wdata_o(mwdata3),
      .mem_rdata_i(mrdata3)
   );

   // Latency-1 memory: read data valid the cycle after the enable cycle.
   always @(posedge clk) begin
      mrdata1 <= (en1 && !we1) ? mem1[maddr1[11:2]] : 32'hDEAD_0001;
      if (en1 && we1) mem1[maddr1[11:2]] = mwdata1;
   end

   // Latency-3 memory: three-stage read pipeline.
   always @(posedge clk) begin
      pipe3[0] <= (en3 && !we3) ? mem3[maddr3[11:2]] : 32'hDEAD_0003;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
      if (en3 && we3) mem3[maddr3[11:2]] = mwdata3;
   end
   assign mrdata3 = pipe3[2];

   always @(posedge clk) begin
      if (en) en_cnt <= en_cnt + 1;
      if (en && we) begin
         we_cnt     <= we_cnt + 1;
         last_waddr <= maddr;
         last_wdata <= mwdata;
      end
      if (req_valid && ready) acc_cnt <= acc_cnt + 1;
   end

   // Issues one request and checks latency, response fields and memory traffic.
   task automatic run_req(input string name, input bit w, input logic [1:0] mop, input bit sgn,
                          input logic [31:0] a, input logic [31:0] wd, input bit hold,
                          input int exp_lat, input logic [31:0] exp_rdata, input bit exp_mis,
                          input int exp_en, input int exp_we);
      int k, en0, we0, acc0;
      bit busy_ready;
      @(negedge clk);
      req_we = w; req_mask = mop; req_sign = sgn; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      en0 = en_cnt; we0 = we_cnt; acc0 = acc_cnt;
      n_checks++;
      if (ready !== 1'b1) begin
         n_fail++; $display("FAIL %s idle_ready got=%b exp=1", name, ready);
      end
      k = 0; busy_ready = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (!hold) req_valid = 1'b0;
         if (resp === 1'b1) begin k = c; break; end
         if (ready !== 1'b0) busy_ready = 1'b1;
      end
      n_checks++;
      if (k != exp_lat) begin
         n_fail++; $display("FAIL %s latency got=%0d exp=%0d (0=timeout)", name, k, exp_lat);
      end
      n_checks++;
      if (rdata !== exp_rdata) begin
         n_fail++; $display("FAIL %s rdata got=%h exp=%h", name, rdata, exp_rdata);
      end
      n_checks++;
      if (mis !== exp_mis) begin
         n_fail++; $display("FAIL %s misalign got=%b exp=%b", name, mis, exp_mis);
      end
      n_checks++;
      if (en_cnt - en0 != exp_en) begin
         n_fail++; $display("FAIL %s mem_en_pulses got=%0d exp=%0d", name, en_cnt - en0, exp_en);
      end
      n_checks++;
      if (we_cnt - we0 != exp_we) begin
         n_fail++; $display("FAIL %s mem_we_pulses got=%0d exp=%0d", name, we_cnt - we0, exp_we);
      end
      if (hold) begin
         n_checks++;
         if (busy_ready) begin
            n_fail++; $display("FAIL %s ready_while_busy got=1 exp=0", name);
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (acc_cnt - acc0 != 1) begin
         n_fail++; $display("FAIL %s accepts got=%0d exp=1", name, acc_cnt - acc0);
      end
      n_checks++;
      if (ready !== 1'b1 || resp !== 1'b0 || mis !== 1'b0) begin
         n_fail++; $display("FAIL %s post_resp ready/resp/mis got=%b%b%b exp=100", name, ready, resp, mis);
      end
   endtask

   task automatic test_reset();
      use3 = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_mask = 2'b00; req_sign = 1'b0;
      req_addr = '0; req_wdata = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (en1 !== 1'b0 || en3 !== 1'b0 || resp1 !== 1'b0 || resp3 !== 1'b0) begin
         n_fail++; $display("FAIL reset_strobes got=%b%b%b%b exp=0000", en1, en3, resp1, resp3);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready got=%b%b exp=11", ready1, ready3);
      end
      n_checks++;
      if (rdata1 !== 32'h0 || maddr1 !== 32'h0 || mwdata1 !== 32'h0 || mis1 !== 1'b0 || we1 !== 1'b0) begin
         n_fail++; $display("FAIL reset_outputs got rdata=%h addr=%h wdata=%h mis=%b we=%b exp=all zero",
                            rdata1, maddr1, mwdata1, mis1, we1);
      end
   endtask

   task automatic test_load_lat1();
      use3 = 1'b0;
      mem1[32'h100 >> 2] = 32'h8081_7F01;
      run_req("ld_b_s_101", 1'b0, 2'b00, 1'b1, 32'h101, 32'h0, 1'b0, 3, 32'h0000_007F, 1'b0, 1, 0);
      run_req("ld_b_s_103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 1'b0, 3, 32'hFFFF_FF80, 1'b0, 1, 0);
      run_req("ld_b_u_103", 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 1'b0, 3, 32'h0000_0080, 1'b0, 1, 0);
      run_req("ld_h_s_102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1'b0, 3, 32'hFFFF_8081, 1'b0, 1, 0);
      run_req("ld_w_100",   1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b0, 3, 32'h8081_7F01, 1'b0, 1, 0);
   endtask

   task automatic test_store_subword();
      use3 = 1'b0;
      mem1[32'h100 >> 2] = 32'h1122_3344;
      run_req("st_h_102", 1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, 1'b0, 4, 32'h0, 1'b0, 2, 1);
      n_checks++;
      if (mem1[32'h100 >> 2] !== 32'hBEEF_3344 || last_waddr !== 32'h100) begin
         n_fail++; $display("FAIL st_h_102_mem got=%h@%h exp=beef3344@00000100", mem1[32'h100 >> 2], last_waddr);
      end
      run_req("st_b_101", 1'b1, 2'b00, 1'b0, 32'h101, 32'h1234_56AB, 1'b0, 4, 32'h0, 1'b0, 2, 1);
      n_checks++;
      if (mem1[32'h100 >> 2] !== 32'hBEEF_AB44) begin
         n_fail++; $display("FAIL st_b_101_mem got=%h exp=beefab44", mem1[32'h100 >> 2]);
      end
   endtask

   task automatic test_store_word();
      use3 = 1'b0;
      mem1[32'h200 >> 2] = 32'h0;
      run_req("st_w_200", 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEAD_BEEF, 1'b0, 2, 32'h0, 1'b0, 1, 1);
      n_checks++;
      if (last_wdata !== 32'hDEAD_BEEF || last_waddr !== 32'h200 || mem1[32'h200 >> 2] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL st_w_200_write got=%h@%h exp=deadbeef@00000200", last_wdata, last_waddr);
      end
   endtask

   task automatic test_misalign();
      use3 = 1'b0;
      run_req("mis_ld_w_102", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b0, 1, 32'h0, 1'b1, 0, 0);
      run_req("mis_st_h_101", 1'b1, 2'b01, 1'b0, 32'h101, 32'h0000_5555, 1'b0, 1, 32'h0, 1'b1, 0, 0);
      run_req("mis_rsvd_101", 1'b0, 2'b11, 1'b0, 32'h101, 32'h0, 1'b0, 1, 32'h0, 1'b1, 0, 0);
      n_checks++;
      if (mem1[32'h100 >> 2] !== 32'hBEEF_AB44) begin
         n_fail++; $display("FAIL mis_mem_unchanged got=%h exp=beefab44", mem1[32'h100 >> 2]);
      end
   endtask

   task automatic test_lat3();
      use3 = 1'b1;
      mem3[32'h200 >> 2] = 32'hA5A5_1234;
      run_req("l3_ld_h_u_202", 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 1'b1, 5, 32'h0000_A5A5, 1'b0, 1, 0);
      run_req("l3_ld_h_s_202", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 1'b1, 5, 32'hFFFF_A5A5, 1'b0, 1, 0);
      run_req("l3_st_h_200",   1'b1, 2'b01, 1'b0, 32'h200, 32'h0000_7777, 1'b1, 6, 32'h0, 1'b0, 2, 1);
      n_checks++;
      if (mem3[32'h200 >> 2] !== 32'hA5A5_7777) begin
         n_fail++; $display("FAIL l3_st_h_mem got=%h exp=a5a57777", mem3[32'h200 >> 2]);
      end
   endtask

   task automatic test_reset_mid_op();
      int we0;
      use3 = 1'b1;
      we0 = we_cnt;
      @(negedge clk);
      req_we = 1'b1; req_mask = 2'b00; req_sign = 1'b0; req_addr = 32'h201; req_wdata = 32'h55;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (en3 !== 1'b0 || maddr3 !== 32'h0 || resp3 !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_strobes got en=%b addr=%h resp=%b exp=0/0/0", en3, maddr3, resp3);
      end
      n_checks++;
      if (rdata3 !== 32'h0) begin
         n_fail++; $display("FAIL rst_mid_rdata got=%h exp=00000000", rdata3);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (ready3 !== 1'b1 || resp3 !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_recover got ready=%b resp=%b exp=1/0", ready3, resp3);
      end
      n_checks++;
      if (we_cnt != we0 || mem3[32'h200 >> 2] !== 32'hA5A5_7777) begin
         n_fail++; $display("FAIL rst_mid_no_write got writes=%0d mem=%h exp=0/a5a57777",
                            we_cnt - we0, mem3[32'h200 >> 2]);
      end
      run_req("rst_mid_ld_w", 1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 1'b0, 5, 32'hA5A5_7777, 1'b0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_load_lat1();
      test_store_subword();
      test_store_word();
      test_misalign();
      test_lat3();
      test_reset_mid_op();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer between the core's memory stage and a synchronous single-port data memory.
- Accepts one request at a time and enforces alignment.
- Loads: issues a read, then formats the returned word with byte/half extraction and sign extension.
- Sub-word stores: performs a read-modify-write (read word, merge lane, write word).
- Word stores: single write.

Parameters:
MEM_LAT, 1, read latency of data memory in cycles (1..7); mem_rdata_i is valid MEM_LAT cycles after the read-enable cycle.

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous reset, active-low
req_valid_i  in  1  request present; must hold stable until accepted
req_ready_o  out  1  controller idle, request accepted this cycle if valid
req_we_i  in  1  1=store, 0=load
mask_op_i  in  2  00=byte, 01=half, 10=word, 11=reserved (treated as word)
sign_i  in  1  sign-extend loaded byte/half
addr_i  in  32  byte address
wdata_i  in  32  store data; low byte/half used for sub-word stores
resp_valid_o  out  1  one-cycle completion pulse
rdata_o  out  32  formatted load data, valid with resp_valid_o
misalign_o  out  1  completion is an alignment fault, valid with resp_valid_o
mem_en_o  out  1  memory access strobe, one cycle per access
mem_we_o  out  1  write enable, qualified by mem_en_o
mem_addr_o  out  32  word address {addr[31:2],2'b00}
mem_wdata_o  out  32  full word to write
mem_rdata_i  in  32  read word from memory

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - State goes to IDLE.
  - All outputs 0 except req_ready_o=1 once out of reset.
  - Latched request, read buffer and wait counter clear.
- Reset mid-operation: any in-flight access is abandoned. mem_en_o drops the same cycle (state-decoded), so no partial write is issued after reset.
- States and memory strobes:
  - IDLE, READ, WAIT, WRITE, RESP.
  - mem_en_o=1 only in READ and WRITE. mem_we_o=1 only in WRITE.
  - mem_addr_o is driven from the latched address in every non-IDLE state, and is 0 in IDLE.
- Accept: in IDLE with req_valid_i=1 at a clock edge, latch req_we, mask_op, sign, addr, wdata. req_ready_o=1 only in IDLE.
- Misalignment:
  - Definition: half with addr[0]=1, or word/reserved with addr[1:0]!=00.
  - Response: IDLE -> RESP, misalign_o=1, rdata_o=0, no memory access.
- Load: IDLE -> READ (1 cycle) -> WAIT (MEM_LAT cycles, counter from MEM_LAT-1 down to 0). On the last WAIT cycle, capture the formatted mem_rdata_i into rdata_o -> RESP. Load latency from accept edge to resp_valid_o = MEM_LAT+2 cycles.
- Word store: IDLE -> WRITE (mem_wdata_o = latched wdata) -> RESP. Latency 2 cycles.
- Sub-word store: IDLE -> READ -> WAIT (capture raw word into buffer) -> WRITE -> RESP.
  - Merged word: buffer with the selected lane replaced.
  - Byte: lane addr[1:0] <- wdata[7:0].
  - Half: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16] <- wdata[15:0].
  - Latency MEM_LAT+3.
- Load formatting:
  - Byte: lane addr[1:0], upper 24 bits = lane bit 7 & sign.
  - Half: lane addr[1], upper 16 bits = lane bit 15 & sign.
  - Word: unchanged.
- RESP: resp_valid_o=1 for exactly one cycle, then IDLE.
  - rdata_o holds its value until the next load capture.
  - misalign_o is cleared on leaving RESP.
  - For stores, rdata_o is 0.
- Back-to-back requests: earliest next accept is the cycle after RESP. The IDLE after RESP is mandatory, so there is no same-cycle accept in RESP.
- req_valid_i while busy is ignored. The requester holds the request until req_ready_o.
- No response backpressure: the consumer must sample resp_valid_o.

Decomposition:
- Shared package lsu_pkg:
  - mask_op encodings MASK_BYTE/MASK_HALF/MASK_WORD.
  - State enum (IDLE, READ, WAIT, WRITE, RESP).
  - Function is_misaligned(mask_op, addr[1:0]).
- One combinational sub-module, lsu_lane_fmt: load extraction/sign-extension and store lane-merge. Inputs: mask_op, sign, addr[1:0], raw word, store data. Outputs: formatted load word, merged store word.
- lsu_ctrl holds the FSM, wait counter, request latch and read buffer.

Test Plan:
- MEM_LAT=1, memory word 0x8081_7F01 at 0x100, load byte signed addr 0x101 -> resp_valid_o pulse 3 cycles after accept, rdata_o=0x0000_007F. Then addr 0x103 signed -> 0xFFFF_FF80. Unsigned at 0x103 -> 0x0000_0080.
- Store half wdata=0x0000_BEEF to addr 0x102 over 0x1122_3344 -> one read then one write of 0xBEEF_3344 to 0x100; resp after 4 cycles; exactly two mem_en_o pulses.
- Store word 0xDEAD_BEEF addr 0x200 -> single mem_en_o/mem_we_o cycle with mem_wdata_o=0xDEAD_BEEF; resp_valid_o 2 cycles after accept.
- Load word at 0x102, and half store at 0x101 -> resp_valid_o with misalign_o=1, zero mem_en_o pulses, memory unchanged.
- MEM_LAT=3, load half unsigned 0x202 over 0xA5A5_1234 -> rdata_o=0x0000_A5A5 at accept+5. Hold req_valid_i high throughout: req_ready_o low until after RESP, exactly one accept per request.
- Assert rst_n_i low during WAIT of a sub-word store -> mem_en_o=0 immediately, no write occurs, req_ready_o=1 after release, memory word unchanged.
